// File: rtl/reg_bank_pkg.sv
// Shared types, address map helpers and error bit indices for the register bank.
package reg_bank_pkg;

  typedef logic [7:0] reg_byte_t;

  localparam reg_byte_t CTRL_ADDR = 8'h00;

  localparam int ERR_WR_BAD = 0;
  localparam int ERR_RD_BAD = 1;
  localparam int ERR_COLL   = 2;

  function automatic reg_byte_t ch_lo_addr(input int k);
    return reg_byte_t'(2 * k + 1);
  endfunction

  function automatic reg_byte_t ch_hi_addr(input int k);
    return reg_byte_t'(2 * k + 2);
  endfunction

  function automatic reg_byte_t stat_addr(input int n);
    return reg_byte_t'(2 * n + 1);
  endfunction

  function automatic reg_byte_t err_addr(input int n);
    return reg_byte_t'(2 * n + 2);
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Byte-wide register access bus between the protocol decoder and the register bank.
interface reg_bank_if;
  import reg_bank_pkg::*;

  logic      reg_wr_i;
  logic      reg_rd_i;
  reg_byte_t reg_addr_i;
  reg_byte_t reg_data_i;
  reg_byte_t reg_data_o;
  logic      reg_rd_valid_o;

  modport master (
    output reg_wr_i, reg_rd_i, reg_addr_i, reg_data_i,
    input  reg_data_o, reg_rd_valid_o
  );

  modport slave (
    input  reg_wr_i, reg_rd_i, reg_addr_i, reg_data_i,
    output reg_data_o, reg_rd_valid_o
  );

endinterface

// File: rtl/reg_bank_channel.sv
// One double-buffered 16-bit channel: staging bytes, committed shadow and update strobe.
module reg_bank_channel
  import reg_bank_pkg::*;
#(
  parameter logic [15:0] CH_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  reg_byte_t   din,
  output reg_byte_t   lo_o,
  output reg_byte_t   hi_o,
  output logic [15:0] data_o,
  output logic        upd_o
);

  // The high-byte write is the commit point: shadow takes the new high byte with the held low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_o   <= CH_RST[7:0];
      hi_o   <= CH_RST[15:8];
      data_o <= CH_RST;
      upd_o  <= 1'b0;
    end else begin
      upd_o <= wr_hi;
      if (wr_lo) lo_o <= din;
      if (wr_hi) begin
        hi_o   <= din;
        data_o <= {din, lo_o};
      end
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Control/status register bank: address decode, CTRL and sticky ERR registers, registered read mux.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter logic [7:0]  CTRL_RST = 8'h00,
  parameter logic [15:0] CH_RST   = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  reg_bank_if.slave              bus,
  input  reg_byte_t              status_i,
  output reg_byte_t              ctrl_o,
  output logic [NUM_CH*16-1:0]   ch_data_o,
  output logic [NUM_CH-1:0]      ch_upd_o,
  output logic                   err_o
);

  localparam reg_byte_t CH_FIRST = ch_lo_addr(0);
  localparam reg_byte_t CH_LAST  = ch_hi_addr(NUM_CH - 1);
  localparam reg_byte_t A_STAT   = stat_addr(NUM_CH);
  localparam reg_byte_t A_ERR    = err_addr(NUM_CH);

  logic      wr, rd, rd_eff;
  reg_byte_t addr;
  logic      hit_ctrl, hit_ch, hit_stat, hit_err, unmapped;
  logic      err_clr;
  logic [2:0] err_set;
  logic [2:0] err_q;
  reg_byte_t  rd_mux;
  reg_byte_t  ch_lo [NUM_CH];
  reg_byte_t  ch_hi [NUM_CH];

  assign wr       = bus.reg_wr_i;
  assign rd       = bus.reg_rd_i;
  assign addr     = bus.reg_addr_i;
  assign rd_eff   = rd && !wr;

  assign hit_ctrl = (addr == CTRL_ADDR);
  assign hit_ch   = (addr >= CH_FIRST) && (addr <= CH_LAST);
  assign hit_stat = (addr == A_STAT);
  assign hit_err  = (addr == A_ERR);
  assign unmapped = !(hit_ctrl || hit_ch || hit_stat || hit_err);

  assign err_set[ERR_WR_BAD] = wr && (unmapped || hit_stat);
  assign err_set[ERR_RD_BAD] = rd_eff && unmapped;
  assign err_set[ERR_COLL]   = wr && rd;
  assign err_clr             = rd_eff && hit_err;
  assign err_o               = |err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam reg_byte_t LO_ADDR = ch_lo_addr(k);
    localparam reg_byte_t HI_ADDR = ch_hi_addr(k);

    reg_bank_channel #(.CH_RST(CH_RST)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_lo  (wr && (addr == LO_ADDR)),
      .wr_hi  (wr && (addr == HI_ADDR)),
      .din    (bus.reg_data_i),
      .lo_o   (ch_lo[k]),
      .hi_o   (ch_hi[k]),
      .data_o (ch_data_o[16*k +: 16]),
      .upd_o  (ch_upd_o[k])
    );
  end

  // Reads expose staging bytes, not the committed shadow; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    if (hit_ctrl)      rd_mux = ctrl_o;
    else if (hit_stat) rd_mux = status_i;
    else if (hit_err)  rd_mux = {5'b00000, err_q};
    else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (addr == ch_lo_addr(k)) rd_mux = ch_lo[k];
        if (addr == ch_hi_addr(k)) rd_mux = ch_hi[k];
      end
    end
  end

  // A clearing read and a newly detected error in the same cycle: the new error survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_o <= CTRL_RST;
      err_q  <= '0;
    end else begin
      if (wr && hit_ctrl) ctrl_o <= bus.reg_data_i;
      err_q <= (err_clr ? 3'b000 : err_q) | err_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_data_o     <= '0;
      bus.reg_rd_valid_o <= 1'b0;
    end else begin
      bus.reg_rd_valid_o <= rd_eff;
      if (rd_eff) bus.reg_data_o <= rd_mux;
    end
  end

endmodule
